// File: rtl/ysyx_22050019_wb_arb_pkg.sv
// Shared definitions for the NPC write-back arbiter: default widths,
// requester indices, the hard-wired zero register and a small helper.
package ysyx_22050019_wb_arb_pkg;

    // Default geometry of the integer register file write port.
    localparam int WB_DW   = 32;
    localparam int WB_AW   = 5;
    localparam int WB_NREQ = 3;

    // Requester slots on the arbiter; the index is also the bit position
    // in req_valid/req_ready and the slice number in req_addr/req_data.
    typedef enum int unsigned {
        REQ_EXU = 0,
        REQ_LSU = 1,
        REQ_CSR = 2
    } req_id_e;

    // x0 is hard-wired to zero; writes to it are accepted but dropped.
    localparam int REG_ZERO = 0;

    // Width of a binary index/pointer over n slots (at least one bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_22050019_rr_pick.sv
// Purely combinational round-robin picker. Scans the request vector
// starting at i_ptr, wrapping modulo N, and returns the first set request
// as a one-hot grant plus its binary index. Shared by several arbiters.
module ysyx_22050019_rr_pick
    import ysyx_22050019_wb_arb_pkg::*;
#(
    parameter int N  = WB_NREQ,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    logic [PW-1:0] w_pos;
    logic          w_found;

    // Priority scan from the pointer; the first valid requester wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so that no
        // path leaves it unassigned; otherwise a latch would be inferred.
        o_grant = '0;
        o_idx   = '0;
        w_pos   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_pos = PW'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
                w_found        = 1'b1;
            end
        end
    end

    assign o_any = w_found;

endmodule

// File: rtl/ysyx_22050019_wb_arb.sv
// Write-back arbiter for the NPC integer register file. Grants at most one
// of NREQ producers per cycle in round-robin order, registers the winner
// onto the single register file write port, and exposes that in-flight
// write to the decode stage through a forwarding compare.
module ysyx_22050019_wb_arb
    import ysyx_22050019_wb_arb_pkg::*;
#(
    parameter int DW   = WB_DW,
    parameter int AW   = WB_AW,
    parameter int NREQ = WB_NREQ
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 rf_wen,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    input  logic [AW-1:0]        fwd_addr,
    output logic                 fwd_hit,
    output logic [DW-1:0]        fwd_data
);

    localparam int PW = ptr_width(NREQ);

    // Architectural state: round-robin pointer and the registered port.
    logic [PW-1:0]   r_rr_ptr;
    logic            r_wen;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_wdata;

    // Picker results and the selected requester's payload.
    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_idx;
    logic            w_any;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;
    logic [PW-1:0]   w_ptr_nxt;
    logic            w_take;

    ysyx_22050019_rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Ready depends only on valid and the pointer; held low during reset
    // so no requester believes its write was accepted.
    assign req_ready = rst ? '0 : w_grant;
    assign w_take    = w_any & ~rst;

    // One-hot mux of the winner's address and data (constant slices only).
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*AW +: AW];
                w_sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Pointer moves to the slot just after the winner, wrapping at NREQ.
    assign w_ptr_nxt = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);

    // Pointer and write-port registers; x0 writes load the port but keep
    // the enable low, and idle cycles hold address/data with enable low.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) begin
            r_rr_ptr <= '0;
            r_wen    <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else if (w_take) begin
            r_rr_ptr <= w_ptr_nxt;
            r_wen    <= (w_sel_addr != AW'(REG_ZERO));
            r_waddr  <= w_sel_addr;
            r_wdata  <= w_sel_data;
        end else begin
            r_wen    <= 1'b0;
        end
    end

    assign rf_wen   = r_wen;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;

    // Forward the in-flight write to decode; x0 never forwards.
    assign fwd_hit  = r_wen & (fwd_addr == r_waddr) & (fwd_addr != AW'(REG_ZERO));
    assign fwd_data = r_wdata;

endmodule
